// File: rtl/play_audio_if.sv
// Playback-side bundle: request/done handshake, sample-buffer read port and audio pins.
// Combinational wiring only; the buffer answers a read in the cycle after the strobe is registered.
interface play_audio_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 10
);
    logic              do_play_audio;
    logic              did_play_audio;
    logic              read_enable;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] data_in;
    logic              audio_pwm;
    logic              audio_sd;

    modport master (
        input  do_play_audio,
        input  data_in,
        output did_play_audio,
        output read_enable,
        output mem_addr,
        output audio_pwm,
        output audio_sd
    );

    modport slave (
        output do_play_audio,
        output data_in,
        input  did_play_audio,
        input  read_enable,
        input  mem_addr,
        input  audio_pwm,
        input  audio_sd
    );
endinterface

// File: rtl/play_audio.sv
// Reads N_SAMPLES buffer words in time order and plays each for SAMPLE_PERIOD clocks as sigma-delta PWM.
// Accept-to-done is N_SAMPLES*SAMPLE_PERIOD+2 clocks; a request waits in START until do_play_audio is seen.
module play_audio #(
    parameter int N_SAMPLES     = 1024,
    parameter int ADDR_W        = 11,
    parameter int DATA_W        = 10,
    parameter int SAMPLE_PERIOD = 978,
    parameter int BIT_REVERSE   = 1
) (
    input  logic         clk,
    input  logic         rst,
    play_audio_if.master bus
);
    localparam int IDX_W = $clog2(N_SAMPLES);
    localparam int CNT_W = $clog2(SAMPLE_PERIOD);

    localparam logic [ADDR_W-1:0] LAST_IDX     = ADDR_W'(N_SAMPLES - 1);
    localparam logic [CNT_W-1:0]  CNT_PREFETCH = CNT_W'(SAMPLE_PERIOD - 3);
    localparam logic [CNT_W-1:0]  CNT_CAPTURE  = CNT_W'(SAMPLE_PERIOD - 2);
    localparam logic [CNT_W-1:0]  CNT_LAST     = CNT_W'(SAMPLE_PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_PRIME,
        S_PLAY,
        S_END
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] index;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] cur_sample;
    logic [DATA_W-1:0] next_sample;
    logic              did_r;
    logic              re_r;
    logic [ADDR_W-1:0] addr_r;
    logic              pwm_r;
    logic              sd_r;

    logic [DATA_W:0]   sum;
    logic [ADDR_W-1:0] index_inc;

    assign sum       = {1'b0, acc} + {1'b0, cur_sample};
    assign index_inc = index + ADDR_W'(1);

    // The capture path stores samples bit-reversed; undo that over the index bits only.
    function automatic logic [ADDR_W-1:0] addr_of(input logic [IDX_W-1:0] idx);
        logic [ADDR_W-1:0] a;
        a = '0;
        for (int b = 0; b < IDX_W; b++)
            a[b] = (BIT_REVERSE != 0) ? idx[IDX_W-1-b] : idx[b];
        return a;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            index       <= '0;
            count       <= '0;
            acc         <= '0;
            cur_sample  <= '0;
            next_sample <= '0;
            did_r       <= 1'b0;
            re_r        <= 1'b0;
            addr_r      <= '0;
            pwm_r       <= 1'b0;
            sd_r        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    did_r <= 1'b0;
                    state <= S_START;
                end
                S_START: begin
                    if (bus.do_play_audio) begin
                        index  <= '0;
                        re_r   <= 1'b1;
                        addr_r <= addr_of('0);
                        state  <= S_PRIME;
                    end
                end
                S_PRIME: begin
                    re_r       <= 1'b0;
                    cur_sample <= bus.data_in;
                    acc        <= '0;
                    count      <= '0;
                    sd_r       <= 1'b1;
                    state      <= S_PLAY;
                end
                S_PLAY: begin
                    {pwm_r, acc} <= sum;
                    re_r         <= 1'b0;
                    // Next word is fetched two cycles ahead so it is ready at the boundary.
                    if (count == CNT_PREFETCH && index < LAST_IDX) begin
                        re_r   <= 1'b1;
                        addr_r <= addr_of(index_inc[IDX_W-1:0]);
                    end
                    if (count == CNT_CAPTURE && index < LAST_IDX)
                        next_sample <= bus.data_in;
                    if (count == CNT_LAST) begin
                        if (index == LAST_IDX) begin
                            state <= S_END;
                        end else begin
                            cur_sample <= next_sample;
                            index      <= index_inc;
                            count      <= '0;
                        end
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                S_END: begin
                    pwm_r <= 1'b0;
                    sd_r  <= 1'b0;
                    did_r <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.did_play_audio = did_r;
    assign bus.read_enable    = re_r;
    assign bus.mem_addr       = addr_r;
    assign bus.audio_pwm      = pwm_r;
    assign bus.audio_sd       = sd_r;
endmodule

// File: tb/tb_play_audio.sv
// Directed bench: four play_audio instances with different sizes, each fed by a small buffer model.
// Buffer models return POISON whenever read_enable is low, so mistimed captures show up in the output.
module tb_play_audio;
    localparam logic [9:0] POISON = 10'h2AA;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    play_audio_if #(.ADDR_W(11), .DATA_W(10)) if_a ();
    play_audio_if #(.ADDR_W(11), .DATA_W(10)) if_b ();
    play_audio_if #(.ADDR_W(11), .DATA_W(10)) if_c ();
    play_audio_if #(.ADDR_W(11), .DATA_W(10)) if_d ();

    logic [9:0] mem_b [2];
    logic [9:0] mem_d [2];

    assign if_a.data_in = if_a.read_enable ? 10'd512 : POISON;
    assign if_b.data_in = if_b.read_enable ? mem_b[if_b.mem_addr[0]] : POISON;
    assign if_c.data_in = if_c.read_enable ? if_c.mem_addr[9:0] : POISON;
    assign if_d.data_in = if_d.read_enable ? mem_d[if_d.mem_addr[0]] : POISON;

    play_audio #(.N_SAMPLES(4), .ADDR_W(11), .DATA_W(10), .SAMPLE_PERIOD(8), .BIT_REVERSE(1))
        dut_a (.clk(clk), .rst(rst), .bus(if_a));
    play_audio #(.N_SAMPLES(2), .ADDR_W(11), .DATA_W(10), .SAMPLE_PERIOD(16), .BIT_REVERSE(1))
        dut_b (.clk(clk), .rst(rst), .bus(if_b));
    play_audio #(.N_SAMPLES(1024), .ADDR_W(11), .DATA_W(10), .SAMPLE_PERIOD(4), .BIT_REVERSE(1))
        dut_c (.clk(clk), .rst(rst), .bus(if_c));
    play_audio #(.N_SAMPLES(2), .ADDR_W(11), .DATA_W(10), .SAMPLE_PERIOD(1024), .BIT_REVERSE(1))
        dut_d (.clk(clk), .rst(rst), .bus(if_d));

    typedef struct {
        logic [9:0] s0;
        logic [9:0] s1;
        int         ones0;
        int         ones1;
    } dvec_t;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int bitrev10(input int i);
        int r;
        r = 0;
        for (int b = 0; b < 10; b++)
            r = (r << 1) | ((i >> b) & 1);
        return r;
    endfunction

    initial begin
        dvec_t tbl [5];
        int    ok, k, sd_cnt, ones, ones0, ones1, pwm_err, re_cnt, did_k, did_cnt, restart_k;
        int    re_k  [4];
        int    addrs [4];
        int    first [5];
        int    addr_err, hi_err;

        tbl[0] = '{10'd0,    10'd1023, 0,    1023};
        tbl[1] = '{10'd1023, 10'd0,    1023, 0};
        tbl[2] = '{10'd512,  10'd512,  512,  512};
        tbl[3] = '{10'd1,    10'd1022, 1,    1022};
        tbl[4] = '{10'd100,  10'd900,  100,  900};

        if_a.do_play_audio = 1'b0;
        if_b.do_play_audio = 1'b0;
        if_c.do_play_audio = 1'b0;
        if_d.do_play_audio = 1'b0;
        mem_b[0] = 10'd100;
        mem_b[1] = 10'd900;
        mem_d[0] = 10'd0;
        mem_d[1] = 10'd0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_did",   int'(if_a.did_play_audio), 0);
        check("reset_re",    int'(if_a.read_enable),    0);
        check("reset_addr",  int'(if_a.mem_addr),       0);
        check("reset_pwm",   int'(if_a.audio_pwm),      0);
        check("reset_sd",    int'(if_a.audio_sd),       0);
        check("reset_state", int'(dut_a.state),         0);
        rst = 1'b0;
        @(negedge clk);

        // N=4, PERIOD=8, all samples 512; k counts cycles after the accept edge.
        if_a.do_play_audio = 1'b1;
        ok = 0;
        for (int i = 0; i < 20 && ok == 0; i++) begin
            @(negedge clk);
            if (if_a.read_enable) ok = 1;
        end
        check("a_accept", ok, 1);
        check("a_addr0", int'(if_a.mem_addr), 0);
        if_a.do_play_audio = 1'b0;
        sd_cnt = 0; ones = 0; pwm_err = 0; re_cnt = 0; did_k = -1; did_cnt = 0;
        for (k = 1; k <= 40; k++) begin
            @(negedge clk);
            if_a.do_play_audio = (k == 10);
            if (if_a.audio_sd) sd_cnt++;
            if (k >= 2 && k <= 33) begin
                if (int'(if_a.audio_pwm) != (k % 2)) pwm_err++;
                if (if_a.audio_pwm) ones++;
            end else if (if_a.audio_pwm) begin
                pwm_err++;
            end
            if (if_a.read_enable) begin
                if (re_cnt < 4) begin
                    re_k[re_cnt]  = k;
                    addrs[re_cnt] = int'(if_a.mem_addr);
                end
                re_cnt++;
            end
            if (if_a.did_play_audio) begin
                if (did_k < 0) did_k = k;
                did_cnt++;
            end
        end
        if_a.do_play_audio = 1'b0;
        // sd rises on the PRIME edge and falls on the END edge: 32 PLAY cycles plus one.
        check("a_sd_cycles", sd_cnt, 33);
        check("a_pwm_pattern_errs", pwm_err, 0);
        check("a_pwm_ones", ones, 16);
        check("a_prefetch_count", re_cnt, 3);
        check("a_prefetch1_cycle", re_k[0], 7);
        check("a_prefetch2_cycle", re_k[1], 15);
        check("a_addr1", addrs[0], 2);
        check("a_addr2", addrs[1], 1);
        check("a_addr3", addrs[2], 3);
        check("a_did_cycle", did_k, 34);
        check("a_did_width", did_cnt, 1);

        // do held high: restart 2 cycles after did, then reset in the middle of the second run.
        if_a.do_play_audio = 1'b1;
        ok = 0;
        for (int i = 0; i < 20 && ok == 0; i++) begin
            @(negedge clk);
            if (if_a.read_enable) ok = 1;
        end
        check("a2_accept", ok, 1);
        did_k = -1; restart_k = -1;
        for (k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (if_a.did_play_audio && did_k < 0) did_k = k;
            if (did_k >= 0 && k > did_k && if_a.read_enable && restart_k < 0) begin
                restart_k = k - did_k;
                if_a.do_play_audio = 1'b0;
            end
        end
        if_a.do_play_audio = 1'b0;
        check("a2_did_cycle", did_k, 34);
        check("a2_restart_gap", restart_k, 2);
        repeat (10) @(negedge clk);
        check("a2_playing_before_rst", int'(if_a.audio_sd), 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_did",   int'(if_a.did_play_audio), 0);
        check("midrst_re",    int'(if_a.read_enable),    0);
        check("midrst_addr",  int'(if_a.mem_addr),       0);
        check("midrst_pwm",   int'(if_a.audio_pwm),      0);
        check("midrst_sd",    int'(if_a.audio_sd),       0);
        check("midrst_state", int'(dut_a.state),         0);
        did_cnt = 0;
        repeat (2) begin
            @(negedge clk);
            if (if_a.did_play_audio) did_cnt++;
        end
        rst = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (if_a.did_play_audio || if_a.audio_sd) did_cnt++;
        end
        check("midrst_no_did", did_cnt, 0);

        // N=2, PERIOD=16, samples 100 then 900.
        if_b.do_play_audio = 1'b1;
        ok = 0;
        for (int i = 0; i < 20 && ok == 0; i++) begin
            @(negedge clk);
            if (if_b.read_enable) ok = 1;
        end
        check("b_accept", ok, 1);
        if_b.do_play_audio = 1'b0;
        re_cnt = 0; did_k = -1;
        for (k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 16) check("b_cur_before_boundary", int'(dut_b.cur_sample), 100);
            if (k == 17) check("b_cur_after_boundary",  int'(dut_b.cur_sample), 900);
            if (if_b.read_enable) begin
                if (re_cnt < 4) begin
                    re_k[re_cnt]  = k;
                    addrs[re_cnt] = int'(if_b.mem_addr);
                end
                re_cnt++;
            end
            if (if_b.did_play_audio && did_k < 0) did_k = k;
        end
        check("b_re_cycles", re_cnt, 1);
        check("b_re_at_count13", re_k[0], 15);
        check("b_re_addr", addrs[0], 1);
        check("b_did_cycle", did_k, 34);

        // N=1024, PERIOD=4: full bit-reversed read order.
        if_c.do_play_audio = 1'b1;
        ok = 0;
        for (int i = 0; i < 20 && ok == 0; i++) begin
            @(negedge clk);
            if (if_c.read_enable) ok = 1;
        end
        check("c_accept", ok, 1);
        if_c.do_play_audio = 1'b0;
        first[0] = int'(if_c.mem_addr);
        re_cnt = 1; addr_err = 0; hi_err = 0; did_k = -1;
        for (k = 1; k <= 5000 && did_k < 0; k++) begin
            @(negedge clk);
            if (if_c.read_enable) begin
                if (re_cnt < 5) first[re_cnt] = int'(if_c.mem_addr);
                if (if_c.mem_addr[10]) hi_err++;
                if (int'(if_c.mem_addr[9:0]) != bitrev10(re_cnt)) addr_err++;
                re_cnt++;
            end
            if (if_c.did_play_audio) did_k = k;
        end
        check("c_addr_0", first[0], 0);
        check("c_addr_1", first[1], 512);
        check("c_addr_2", first[2], 256);
        check("c_addr_3", first[3], 768);
        check("c_addr_4", first[4], 128);
        check("c_read_pulses", re_cnt, 1024);
        check("c_addr_order_errs", addr_err, 0);
        check("c_addr_msb_errs", hi_err, 0);
        check("c_did_cycle", did_k, 4098);

        // N=2, PERIOD=1024: ones per 1024-cycle sample equal the sample value.
        for (int v = 0; v < 5; v++) begin
            mem_d[0] = tbl[v].s0;
            mem_d[1] = tbl[v].s1;
            if_d.do_play_audio = 1'b1;
            ok = 0;
            for (int i = 0; i < 20 && ok == 0; i++) begin
                @(negedge clk);
                if (if_d.read_enable) ok = 1;
            end
            check($sformatf("d%0d_accept", v), ok, 1);
            if_d.do_play_audio = 1'b0;
            ones0 = 0; ones1 = 0; did_k = -1;
            for (k = 1; k <= 2060 && did_k < 0; k++) begin
                @(negedge clk);
                if (if_d.audio_pwm) begin
                    if (k >= 2 && k <= 1025) ones0++;
                    else if (k >= 1026 && k <= 2049) ones1++;
                end
                if (if_d.did_play_audio) did_k = k;
            end
            check($sformatf("d%0d_ones_s0", v), ones0, tbl[v].ones0);
            check($sformatf("d%0d_ones_s1", v), ones1, tbl[v].ones1);
            check($sformatf("d%0d_did_cycle", v), did_k, 2050);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
